// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART RX host controller.
//   - Byte addresses of the APB-lite register map (bits [1:0] always zero).
//   - Bit positions inside CTRL, IRQ_EN/IRQ_STAT and CMD.
//   - Config sequencer state type and the applied-configuration record.
//   - data_bits_ok(): legality check for the CTRL.data_bits field.
package uart_rx_ctrl_pkg;

    localparam logic [4:0] ADDR_CTRL     = 5'h00;
    localparam logic [4:0] ADDR_BAUD     = 5'h04;
    localparam logic [4:0] ADDR_DATA     = 5'h08;
    localparam logic [4:0] ADDR_STATUS   = 5'h0C;
    localparam logic [4:0] ADDR_IRQ_EN   = 5'h10;
    localparam logic [4:0] ADDR_IRQ_STAT = 5'h14;
    localparam logic [4:0] ADDR_CMD      = 5'h18;

    localparam int CTRL_LSB_FIRST = 0;
    localparam int CTRL_STOP_BITS = 1;
    localparam int CTRL_PARITY_LO = 2;
    localparam int CTRL_DBITS_LO  = 4;
    localparam int CTRL_FLUSH     = 8;
    localparam int CTRL_W         = 9;

    localparam int IRQ_THRESH   = 0;
    localparam int IRQ_ERROR    = 1;
    localparam int IRQ_OVERFLOW = 2;
    localparam int IRQ_TIMEOUT  = 3;
    localparam int IRQ_BREAK    = 4;
    localparam int IRQ_CFG_ERR  = 5;
    localparam int IRQ_NUM      = 6;

    localparam int CMD_FIFO_CLEAR  = 0;
    localparam int CMD_ERROR_CLEAR = 1;

    typedef enum logic [1:0] {
        CFG_IDLE  = 2'd0,
        CFG_WAIT  = 2'd1,
        CFG_APPLY = 2'd2
    } cfg_state_t;

    typedef struct packed {
        logic [31:0] baud;
        logic [3:0]  data_bits;
        logic [1:0]  parity;
        logic        stop_bits;
        logic        lsb_first;
    } uart_cfg_t;

    // The receiver supports 5 to 9 data bits per frame.
    function automatic logic data_bits_ok(input logic [3:0] db);
        return (db >= 4'd5) && (db <= 4'd9);
    endfunction

endpackage

// File: rtl/uart_rx_irq_ctrl.sv
// Interrupt block of the UART RX host controller.
// Turns receiver status levels into sticky W1C status bits and a level irq.
//   clk, rst_n        : clock, async active-low reset
//   error_i..break_i  : receiver status levels (rising edge sets a bit)
//   cfg_err_i         : one-cycle pulse from a rejected CTRL/BAUD write
//   fifo_count_i      : FIFO occupancy
//   rx_thresh_i       : occupancy threshold, 0 disables the threshold event
//   irq_en_i          : per-bit interrupt enables
//   w1c_i             : clear mask, non-zero only during an IRQ_STAT write
//   irq_stat_o, irq_o : sticky status and registered interrupt line
module uart_rx_irq_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               error_i,
    input  logic               overflow_i,
    input  logic               timeout_i,
    input  logic               break_i,
    input  logic               cfg_err_i,
    input  logic [CNT_W-1:0]   fifo_count_i,
    input  logic [CNT_W-1:0]   rx_thresh_i,
    input  logic [IRQ_NUM-1:0] irq_en_i,
    input  logic [IRQ_NUM-1:0] w1c_i,
    output logic [IRQ_NUM-1:0] irq_stat_o,
    output logic               irq_o
);

    logic [3:0]         evt_s;
    logic [3:0]         rise_s;
    logic [3:0]         evt_prev_q;
    logic [CNT_W-1:0]   cnt_prev_q;
    logic               thresh_hit_s;
    logic [IRQ_NUM-1:0] set_s;
    logic [IRQ_NUM-1:0] stat_d;
    logic [IRQ_NUM-1:0] stat_q;
    logic               irq_q;

    // Event detection and sticky-status next state; a new event beats a clear.
    always_comb begin
        evt_s  = {break_i, timeout_i, overflow_i, error_i};
        rise_s = evt_s & ~evt_prev_q;
        thresh_hit_s = (rx_thresh_i != {CNT_W{1'b0}}) &&
                       (cnt_prev_q < rx_thresh_i) &&
                       (fifo_count_i >= rx_thresh_i);
        set_s               = {IRQ_NUM{1'b0}};
        set_s[IRQ_THRESH]   = thresh_hit_s;
        set_s[IRQ_ERROR]    = rise_s[0];
        set_s[IRQ_OVERFLOW] = rise_s[1];
        set_s[IRQ_TIMEOUT]  = rise_s[2];
        set_s[IRQ_BREAK]    = rise_s[3];
        set_s[IRQ_CFG_ERR]  = cfg_err_i;
        stat_d = (stat_q & ~w1c_i) | set_s;
    end

    // Edge/transition history, sticky status and the registered irq line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_prev_q <= 4'b0000;
            cnt_prev_q <= {CNT_W{1'b0}};
            stat_q     <= {IRQ_NUM{1'b0}};
            irq_q      <= 1'b0;
        end else begin
            evt_prev_q <= evt_s;
            cnt_prev_q <= fifo_count_i;
            stat_q     <= stat_d;
            irq_q      <= |(stat_q & irq_en_i);
        end
    end

    assign irq_stat_o = stat_q;
    assign irq_o      = irq_q;

endmodule

// File: rtl/uart_rx_host_ctrl.sv
// APB-lite host controller for the UART receiver.
// Register file (CTRL, BAUD, DATA, STATUS, IRQ_EN, IRQ_STAT, CMD), FIFO pop
// handshake and a config sequencer that holds CTRL/BAUD changes in shadow
// registers until the line is between frames.
//   clk, rst_n                     : clock, async active-low reset
//   psel/penable/pwrite/paddr/pwdata, prdata/pready : APB-lite slave, no waits
//   rx_data, rx_data_valid, rx_data_read, fifo_count : FIFO head and pop
//   frame_active .. overflow_error : receiver status inputs
//   baud_rate .. lsb_first         : applied configuration
//   error_clear, fifo_clear        : one-cycle control pulses
//   irq                            : level interrupt
module uart_rx_host_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int MAX_DATA_BITS     = 9,
    parameter int FIFO_DEPTH        = 16,
    parameter int DEFAULT_BAUD_RATE = 115200,
    parameter int DEFAULT_DATA_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [4:0]                 paddr,
    input  logic [31:0]                pwdata,
    output logic [31:0]                prdata,
    output logic                       pready,
    input  logic [MAX_DATA_BITS-1:0]   rx_data,
    input  logic                       rx_data_valid,
    output logic                       rx_data_read,
    input  logic [$clog2(FIFO_DEPTH):0] fifo_count,
    input  logic                       frame_active,
    input  logic                       error_detected,
    input  logic                       framing_error,
    input  logic                       parity_error,
    input  logic                       break_detect,
    input  logic                       timeout_detect,
    input  logic                       overflow_error,
    output logic [31:0]                baud_rate,
    output logic [3:0]                 data_bits,
    output logic [1:0]                 parity_mode,
    output logic                       stop_bits,
    output logic                       lsb_first,
    output logic                       error_clear,
    output logic                       fifo_clear,
    output logic                       irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CTRL_W-1:0] CTRL_RST = {1'b0, 4'(DEFAULT_DATA_BITS), 2'b00, 1'b0, 1'b1};
    localparam uart_cfg_t CFG_RST = '{
        baud:      32'(DEFAULT_BAUD_RATE),
        data_bits: 4'(DEFAULT_DATA_BITS),
        parity:    2'b00,
        stop_bits: 1'b0,
        lsb_first: 1'b1
    };

    logic               access_s, wr_s, rd_s;
    logic [4:0]         addr_s;
    logic               unused_s;
    logic               ctrl_wr_s, baud_wr_s, ctrl_ok_s, baud_ok_s;
    logic               cfg_wr_s, cfg_err_s, cmd_wr_s, irq_en_wr_s;
    logic [IRQ_NUM-1:0] w1c_s;
    logic [IRQ_NUM-1:0] irq_stat_s;
    logic               cfg_pending_s;
    logic [31:0]        rdata_s;

    logic [CTRL_W-1:0]  ctrl_shadow_q;
    logic [31:0]        baud_shadow_q;
    logic [IRQ_NUM-1:0] irq_en_q;
    logic [CNT_W-1:0]   rx_thresh_q;
    cfg_state_t         state_q, state_d;
    uart_cfg_t          cfg_q, cfg_d;
    logic               fifo_clear_q, fifo_clear_d;
    logic               error_clear_q, error_clear_d;

    assign access_s = psel & penable;
    assign wr_s     = access_s & pwrite;
    assign rd_s     = access_s & ~pwrite;
    assign addr_s   = {paddr[4:2], 2'b00};
    assign unused_s = ^paddr[1:0];

    // Write decode; rejected CTRL/BAUD writes only raise the cfg error event.
    always_comb begin
        ctrl_wr_s   = wr_s && (addr_s == ADDR_CTRL);
        baud_wr_s   = wr_s && (addr_s == ADDR_BAUD);
        cmd_wr_s    = wr_s && (addr_s == ADDR_CMD);
        irq_en_wr_s = wr_s && (addr_s == ADDR_IRQ_EN);
        ctrl_ok_s   = data_bits_ok(pwdata[CTRL_DBITS_LO +: 4]);
        baud_ok_s   = (pwdata != 32'h0000_0000);
        cfg_wr_s    = (ctrl_wr_s && ctrl_ok_s) || (baud_wr_s && baud_ok_s);
        cfg_err_s   = (ctrl_wr_s && !ctrl_ok_s) || (baud_wr_s && !baud_ok_s);
        if (wr_s && (addr_s == ADDR_IRQ_STAT)) begin
            w1c_s = pwdata[IRQ_NUM-1:0];
        end else begin
            w1c_s = {IRQ_NUM{1'b0}};
        end
    end

    // Software-visible registers: config shadows and interrupt enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_shadow_q <= CTRL_RST;
            baud_shadow_q <= 32'(DEFAULT_BAUD_RATE);
            irq_en_q      <= {IRQ_NUM{1'b0}};
            rx_thresh_q   <= {CNT_W{1'b0}};
        end else begin
            if (ctrl_wr_s && ctrl_ok_s) begin
                ctrl_shadow_q <= pwdata[CTRL_W-1:0];
            end
            if (baud_wr_s && baud_ok_s) begin
                baud_shadow_q <= pwdata;
            end
            if (irq_en_wr_s) begin
                irq_en_q    <= pwdata[IRQ_NUM-1:0];
                rx_thresh_q <= pwdata[16 +: CNT_W];
            end
        end
    end

    // Config sequencer next state plus pulse generation. CMD pulses and the
    // apply-time flush OR together so a coincident pair is a single pulse.
    always_comb begin
        state_d       = state_q;
        cfg_d         = cfg_q;
        fifo_clear_d  = cmd_wr_s & pwdata[CMD_FIFO_CLEAR];
        error_clear_d = cmd_wr_s & pwdata[CMD_ERROR_CLEAR];
        case (state_q)
            CFG_IDLE: begin
                if (cfg_wr_s) begin
                    state_d = CFG_WAIT;
                end else begin
                    state_d = CFG_IDLE;
                end
            end
            CFG_WAIT: begin
                if (!frame_active) begin
                    state_d = CFG_APPLY;
                end else begin
                    state_d = CFG_WAIT;
                end
            end
            CFG_APPLY: begin
                cfg_d = '{
                    baud:      baud_shadow_q,
                    data_bits: ctrl_shadow_q[CTRL_DBITS_LO +: 4],
                    parity:    ctrl_shadow_q[CTRL_PARITY_LO +: 2],
                    stop_bits: ctrl_shadow_q[CTRL_STOP_BITS],
                    lsb_first: ctrl_shadow_q[CTRL_LSB_FIRST]
                };
                fifo_clear_d  = fifo_clear_d  | ctrl_shadow_q[CTRL_FLUSH];
                error_clear_d = error_clear_d | ctrl_shadow_q[CTRL_FLUSH];
                // A write landing in the apply cycle was not copied; go round again.
                if (cfg_wr_s) begin
                    state_d = CFG_WAIT;
                end else begin
                    state_d = CFG_IDLE;
                end
            end
            default: begin
                state_d = CFG_IDLE;
            end
        endcase
    end

    // Sequencer state, applied configuration and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CFG_IDLE;
            cfg_q         <= CFG_RST;
            fifo_clear_q  <= 1'b0;
            error_clear_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            fifo_clear_q  <= fifo_clear_d;
            error_clear_q <= error_clear_d;
        end
    end

    assign cfg_pending_s = (state_q != CFG_IDLE);

    // Read mux; CMD and unmapped addresses fall through to zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (addr_s)
            ADDR_CTRL: rdata_s[CTRL_W-1:0] = ctrl_shadow_q;
            ADDR_BAUD: rdata_s = baud_shadow_q;
            ADDR_DATA: begin
                if (rx_data_valid) begin
                    rdata_s[31]                = 1'b1;
                    rdata_s[MAX_DATA_BITS-1:0] = rx_data;
                end else begin
                    rdata_s = 32'h0000_0000;
                end
            end
            ADDR_STATUS: begin
                rdata_s[0]          = rx_data_valid;
                rdata_s[1]          = frame_active;
                rdata_s[2]          = cfg_pending_s;
                rdata_s[3]          = error_detected;
                rdata_s[4]          = framing_error;
                rdata_s[5]          = parity_error;
                rdata_s[6]          = break_detect;
                rdata_s[7]          = timeout_detect;
                rdata_s[8]          = overflow_error;
                rdata_s[16 +: CNT_W] = fifo_count;
            end
            ADDR_IRQ_EN: begin
                rdata_s[IRQ_NUM-1:0] = irq_en_q;
                rdata_s[16 +: CNT_W] = rx_thresh_q;
            end
            ADDR_IRQ_STAT: rdata_s[IRQ_NUM-1:0] = irq_stat_s;
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    uart_rx_irq_ctrl #(
        .CNT_W (CNT_W)
    ) u_irq (
        .clk          (clk),
        .rst_n        (rst_n),
        .error_i      (error_detected),
        .overflow_i   (overflow_error),
        .timeout_i    (timeout_detect),
        .break_i      (break_detect),
        .cfg_err_i    (cfg_err_s),
        .fifo_count_i (fifo_count),
        .rx_thresh_i  (rx_thresh_q),
        .irq_en_i     (irq_en_q),
        .w1c_i        (w1c_s),
        .irq_stat_o   (irq_stat_s),
        .irq_o        (irq)
    );

    assign pready       = access_s;
    assign prdata       = access_s ? rdata_s : 32'h0000_0000;
    assign rx_data_read = rd_s && (addr_s == ADDR_DATA) && rx_data_valid;
    assign baud_rate    = cfg_q.baud;
    assign data_bits    = cfg_q.data_bits;
    assign parity_mode  = cfg_q.parity;
    assign stop_bits    = cfg_q.stop_bits;
    assign lsb_first    = cfg_q.lsb_first;
    assign fifo_clear   = fifo_clear_q;
    assign error_clear  = error_clear_q;

endmodule

// File: tb/tb_uart_rx_host_ctrl.sv
// Directed testbench for uart_rx_host_ctrl.
module tb_uart_rx_host_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready;
    logic [8:0]  rx_data;
    logic        rx_data_valid, rx_data_read;
    logic [4:0]  fifo_count;
    logic        frame_active, error_detected, framing_error, parity_error;
    logic        break_detect, timeout_detect, overflow_error;
    logic [31:0] baud_rate;
    logic [3:0]  data_bits;
    logic [1:0]  parity_mode;
    logic        stop_bits, lsb_first, error_clear, fifo_clear, irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_host_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_read(rx_data_read),
        .fifo_count(fifo_count), .frame_active(frame_active),
        .error_detected(error_detected), .framing_error(framing_error),
        .parity_error(parity_error), .break_detect(break_detect),
        .timeout_detect(timeout_detect), .overflow_error(overflow_error),
        .baud_rate(baud_rate), .data_bits(data_bits), .parity_mode(parity_mode),
        .stop_bits(stop_bits), .lsb_first(lsb_first),
        .error_clear(error_clear), .fifo_clear(fifo_clear), .irq(irq)
    );

    // APB write; returns 1 time unit after the ACCESS clock edge.
    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // APB read; samples prdata, pready and rx_data_read mid ACCESS cycle.
    task automatic apb_read(input logic [4:0] a, output logic [31:0] d,
                            output logic pop, output logic rdy);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #4;
        d = prdata; pop = rx_data_read; rdy = pready;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic pop, rdy;
        @(negedge clk);
        n_cmp++; if ({prdata, pready, rx_data_read, error_clear, fifo_clear, irq} !== {32'h0, 5'b00000}) begin
            n_err++; $display("FAIL reset_outs: got %h/%b%b%b%b%b expected 0/00000", prdata, pready, rx_data_read, error_clear, fifo_clear, irq); end
        n_cmp++; if ({baud_rate, data_bits, parity_mode, stop_bits, lsb_first} !== {32'd115200, 4'd8, 2'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL reset_cfg: got baud=%0d db=%0d par=%0d stop=%b lsb=%b", baud_rate, data_bits, parity_mode, stop_bits, lsb_first); end
        apb_read(5'h00, d, pop, rdy);
        n_cmp++; if (d !== 32'h0000_0081) begin n_err++; $display("FAIL reset_ctrl: got %h expected 00000081", d); end
        n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL pready: got %b expected 1", rdy); end
        apb_read(5'h04, d, pop, rdy);
        n_cmp++; if (d !== 32'd115200) begin n_err++; $display("FAIL reset_baud: got %0d expected 115200", d); end
    endtask

    task automatic test_data();
        logic [31:0] d; logic pop, rdy;
        rx_data_valid = 1'b1; rx_data = 9'h1A5;
        apb_read(5'h08, d, pop, rdy);
        n_cmp++; if ({d, pop} !== {32'h8000_01A5, 1'b1}) begin n_err++; $display("FAIL data_pop1: got %h pop=%b expected 800001a5 pop=1", d, pop); end
        rx_data = 9'h055;
        apb_read(5'h08, d, pop, rdy);
        n_cmp++; if ({d, pop} !== {32'h8000_0055, 1'b1}) begin n_err++; $display("FAIL data_pop2: got %h pop=%b expected 80000055 pop=1", d, pop); end
        @(negedge clk);
        n_cmp++; if (rx_data_read !== 1'b0) begin n_err++; $display("FAIL pop_idle: got %b expected 0", rx_data_read); end
        rx_data_valid = 1'b0;
        apb_read(5'h08, d, pop, rdy);
        n_cmp++; if ({d, pop} !== {32'h0, 1'b0}) begin n_err++; $display("FAIL data_empty: got %h pop=%b expected 0 pop=0", d, pop); end
        rx_data = 9'h000;
    endtask

    task automatic test_cfg_defer();
        logic [31:0] d; logic pop, rdy;
        frame_active = 1'b1;
        apb_write(5'h00, 32'h0000_017E);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if ({data_bits, parity_mode, stop_bits, lsb_first, fifo_clear, error_clear} !== {4'd8, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
                n_err++; $display("FAIL defer_hold[%0d]: got db=%0d par=%0d stop=%b lsb=%b fc=%b ec=%b", i, data_bits, parity_mode, stop_bits, lsb_first, fifo_clear, error_clear); end
        end
        apb_read(5'h0C, d, pop, rdy);
        n_cmp++; if (d !== 32'h0000_0006) begin n_err++; $display("FAIL defer_status: got %h expected 00000006", d); end
        @(posedge clk); #1; frame_active = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if ({data_bits, fifo_clear, error_clear} !== {4'd8, 2'b00}) begin n_err++; $display("FAIL defer_apply_cycle: got db=%0d fc=%b ec=%b expected 8 0 0", data_bits, fifo_clear, error_clear); end
        @(negedge clk);
        n_cmp++; if ({data_bits, parity_mode, stop_bits, lsb_first, fifo_clear, error_clear} !== {4'd7, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL defer_applied: got db=%0d par=%0d stop=%b lsb=%b fc=%b ec=%b expected 7 3 1 0 1 1", data_bits, parity_mode, stop_bits, lsb_first, fifo_clear, error_clear); end
        @(negedge clk);
        n_cmp++; if ({fifo_clear, error_clear} !== 2'b00) begin n_err++; $display("FAIL flush_once: got %b%b expected 00", fifo_clear, error_clear); end
        apb_read(5'h0C, d, pop, rdy);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL pending_clr: got %h expected 0", d); end
        apb_read(5'h00, d, pop, rdy);
        n_cmp++; if (d !== 32'h0000_017E) begin n_err++; $display("FAIL ctrl_rb: got %h expected 0000017e", d); end
    endtask

    task automatic test_cfg_immediate();
        apb_write(5'h04, 32'h0000_2580);
        @(negedge clk);
        n_cmp++; if (baud_rate !== 32'd115200) begin n_err++; $display("FAIL imm_wait: got %0d expected 115200", baud_rate); end
        @(negedge clk);
        n_cmp++; if (baud_rate !== 32'd115200) begin n_err++; $display("FAIL imm_apply: got %0d expected 115200", baud_rate); end
        @(negedge clk);
        n_cmp++; if ({baud_rate, fifo_clear} !== {32'h0000_2580, 1'b1}) begin n_err++; $display("FAIL imm_done: got %h fc=%b expected 00002580 fc=1", baud_rate, fifo_clear); end
    endtask

    task automatic test_cfg_err();
        logic [31:0] d; logic pop, rdy;
        apb_write(5'h10, 32'h0000_0020);
        apb_write(5'h00, 32'h0000_0040);
        apb_write(5'h04, 32'h0000_0000);
        apb_write(5'h00, 32'h0000_00A1);
        apb_read(5'h14, d, pop, rdy);
        n_cmp++; if (d !== 32'h0000_0020) begin n_err++; $display("FAIL cfg_err_stat: got %h expected 00000020", d); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL cfg_err_irq: got %b expected 1", irq); end
        apb_read(5'h0C, d, pop, rdy);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL cfg_err_pending: got %h expected 0", d); end
        apb_read(5'h00, d, pop, rdy);
        n_cmp++; if (d !== 32'h0000_017E) begin n_err++; $display("FAIL cfg_err_ctrl: got %h expected 0000017e", d); end
        apb_read(5'h04, d, pop, rdy);
        n_cmp++; if (d !== 32'h0000_2580) begin n_err++; $display("FAIL cfg_err_baud: got %h expected 00002580", d); end
        n_cmp++; if ({data_bits, baud_rate} !== {4'd7, 32'h0000_2580}) begin n_err++; $display("FAIL cfg_err_applied: got db=%0d baud=%h", data_bits, baud_rate); end
        apb_write(5'h14, 32'h0000_0020);
        apb_write(5'h10, 32'h0000_0000);
        apb_read(5'h14, d, pop, rdy);
        n_cmp++; if ({d, irq} !== {32'h0, 1'b0}) begin n_err++; $display("FAIL cfg_err_w1c: got %h irq=%b expected 0 irq=0", d, irq); end
        apb_write(5'h00, 32'h0000_0091);
        repeat (4) @(negedge clk);
        n_cmp++; if ({data_bits, parity_mode, stop_bits, lsb_first} !== {4'd9, 2'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL db9_applied: got db=%0d par=%0d stop=%b lsb=%b expected 9 0 0 1", data_bits, parity_mode, stop_bits, lsb_first); end
    endtask

    task automatic test_irq();
        logic [31:0] d; logic pop, rdy;
        fifo_count = 5'd2;
        apb_write(5'h10, 32'h0003_0001);
        repeat (2) @(posedge clk); #1;
        fifo_count = 5'd3;
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL thresh_c0: got %b expected 0", irq); end
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL thresh_c1: got %b expected 0", irq); end
        @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL thresh_irq: got %b expected 1", irq); end
        apb_read(5'h14, d, pop, rdy);
        n_cmp++; if (d !== 32'h0000_0001) begin n_err++; $display("FAIL thresh_stat: got %h expected 00000001", d); end
        // W1C of bit 0 while overflow rises in the same ACCESS cycle
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h14; pwdata = 32'h1;
        @(posedge clk); #1; penable = 1'b1; overflow_error = 1'b1;
        @(posedge clk); #1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apb_read(5'h14, d, pop, rdy);
        n_cmp++; if ({d, irq} !== {32'h0000_0004, 1'b0}) begin n_err++; $display("FAIL w1c_ovf: got %h irq=%b expected 00000004 irq=0", d, irq); end
        // W1C of bit 2 colliding with a new overflow edge: set wins
        overflow_error = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h14; pwdata = 32'h4;
        @(posedge clk); #1; penable = 1'b1; overflow_error = 1'b1;
        @(posedge clk); #1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apb_read(5'h14, d, pop, rdy);
        n_cmp++; if (d !== 32'h0000_0004) begin n_err++; $display("FAIL set_wins: got %h expected 00000004", d); end
        overflow_error = 1'b0;
        apb_write(5'h14, 32'h0000_0004);
        apb_read(5'h14, d, pop, rdy);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL w1c_clr: got %h expected 0", d); end
        fifo_count = 5'd0;
    endtask

    task automatic test_cmd();
        logic [31:0] d; logic pop, rdy;
        apb_write(5'h18, 32'h0000_0003);
        @(negedge clk);
        n_cmp++; if ({fifo_clear, error_clear} !== 2'b11) begin n_err++; $display("FAIL cmd_pulse: got %b%b expected 11", fifo_clear, error_clear); end
        @(negedge clk);
        n_cmp++; if ({fifo_clear, error_clear} !== 2'b00) begin n_err++; $display("FAIL cmd_one_cycle: got %b%b expected 00", fifo_clear, error_clear); end
        apb_write(5'h18, 32'h0000_0002);
        @(negedge clk);
        n_cmp++; if ({fifo_clear, error_clear} !== 2'b01) begin n_err++; $display("FAIL cmd_err_only: got %b%b expected 01", fifo_clear, error_clear); end
        apb_read(5'h18, d, pop, rdy);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL cmd_read: got %h expected 0", d); end
        apb_write(5'h1C, 32'hFFFF_FFFF);
        apb_read(5'h1C, d, pop, rdy);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped: got %h expected 0", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic pop, rdy;
        frame_active = 1'b1;
        apb_write(5'h00, 32'h0000_015E);
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({baud_rate, data_bits, lsb_first, fifo_clear, error_clear, irq} !== {32'd115200, 4'd8, 1'b1, 3'b000}) begin
            n_err++; $display("FAIL rst_mid_outs: got baud=%0d db=%0d lsb=%b pulses=%b%b irq=%b", baud_rate, data_bits, lsb_first, fifo_clear, error_clear, irq); end
        @(posedge clk); #1; rst_n = 1'b1; frame_active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if ({data_bits, fifo_clear, error_clear} !== {4'd8, 2'b00}) begin
                n_err++; $display("FAIL rst_mid_noapply[%0d]: got db=%0d fc=%b ec=%b", i, data_bits, fifo_clear, error_clear); end
        end
        apb_read(5'h0C, d, pop, rdy);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_mid_status: got %h expected 0", d); end
        apb_read(5'h00, d, pop, rdy);
        n_cmp++; if (d !== 32'h0000_0081) begin n_err++; $display("FAIL rst_mid_ctrl: got %h expected 00000081", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 5'h00; pwdata = 32'h0;
        rx_data = 9'h000; rx_data_valid = 1'b0; fifo_count = 5'd0;
        frame_active = 1'b0; error_detected = 1'b0; framing_error = 1'b0;
        parity_error = 1'b0; break_detect = 1'b0; timeout_detect = 1'b0;
        overflow_error = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        test_reset();
        test_data();
        test_cfg_defer();
        test_cfg_immediate();
        test_cfg_err();
        test_irq();
        test_cmd();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
